// File: rtl/mult_pipeline.sv
// Five-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Never stalls; in-flight destinations are exported for hazard detection.
module mult_pipeline (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        kill_i,
  input  logic        mult_valid_i,
  input  logic [31:0] mult_rs1_data_i,
  input  logic [31:0] mult_rs2_data_i,
  input  logic [4:0]  mult_write_addr_i,
  input  logic [31:0] mult_instruction_i,
  input  logic [31:0] mult_pc_i,
  output logic [31:0] mult5_int_write_data_o,
  output logic [4:0]  mult5_write_addr_o,
  output logic        mult5_int_write_enable_o,
  output logic [31:0] mult5_instruction_o,
  output logic [31:0] mult5_pc_o,
  output logic [4:0]  mult_pend_valid_o,
  output logic [24:0] mult_pend_addr_o
);

  logic [4:0]  vld;
  logic [4:0]  addr  [5];
  logic [31:0] instr [5];
  logic [31:0] pc    [5];

  logic [32:0] a1, b1, a2;
  logic [16:0] bhi2;
  logic [49:0] pp_lo2, pp_lo3;
  logic [47:0] pp_hi3;
  logic [63:0] prod4;
  logic [31:0] res5;

  logic        accept;
  logic [1:0]  func;
  logic        a_sgn, b_sgn;
  logic [49:0] pp_lo_c;
  logic [47:0] pp_hi_c;
  logic [63:0] prod_c;
  logic [31:0] res_c;

  assign func   = mult_instruction_i[13:12];
  assign accept = mult_valid_i
                & (mult_instruction_i[6:0]   == 7'b0110011)
                & (mult_instruction_i[31:25] == 7'b0000001)
                & ~mult_instruction_i[14];
  assign a_sgn  = (func != 2'b11);
  assign b_sgn  = ~func[1];

  // Product split on B: low 16 bits (unsigned) in M2, high 17 bits (signed) in M3.
  assign pp_lo_c = {{17{a1[32]}}, a1} * {34'b0, b1[15:0]};
  assign pp_hi_c = {{15{a2[32]}}, a2} * {{31{bhi2[16]}}, bhi2};
  assign prod_c  = {{14{pp_lo3[49]}}, pp_lo3} + {pp_hi3, 16'b0};
  assign res_c   = (instr[3][13:12] == 2'b00) ? prod4[31:0] : prod4[63:32];

  // Only M1 is gated: bubbles hold all-zero fields, so later stages just copy.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      vld <= '0;
      for (int i = 0; i < 5; i++) begin
        addr[i]  <= '0;
        instr[i] <= '0;
        pc[i]    <= '0;
      end
      a1 <= '0; b1 <= '0; a2 <= '0; bhi2 <= '0;
      pp_lo2 <= '0; pp_lo3 <= '0; pp_hi3 <= '0; prod4 <= '0; res5 <= '0;
    end else if (kill_i) begin
      vld <= '0;
      for (int i = 0; i < 5; i++) begin
        addr[i]  <= '0;
        instr[i] <= '0;
        pc[i]    <= '0;
      end
      a1 <= '0; b1 <= '0; a2 <= '0; bhi2 <= '0;
      pp_lo2 <= '0; pp_lo3 <= '0; pp_hi3 <= '0; prod4 <= '0; res5 <= '0;
    end else begin
      vld      <= {vld[3:0], accept};
      addr[0]  <= accept ? mult_write_addr_i : '0;
      instr[0] <= accept ? mult_instruction_i : '0;
      pc[0]    <= accept ? mult_pc_i : '0;
      a1       <= accept ? {a_sgn & mult_rs1_data_i[31], mult_rs1_data_i} : '0;
      b1       <= accept ? {b_sgn & mult_rs2_data_i[31], mult_rs2_data_i} : '0;
      for (int i = 1; i < 5; i++) begin
        addr[i]  <= addr[i-1];
        instr[i] <= instr[i-1];
        pc[i]    <= pc[i-1];
      end
      a2     <= a1;
      bhi2   <= b1[32:16];
      pp_lo2 <= pp_lo_c;
      pp_lo3 <= pp_lo2;
      pp_hi3 <= pp_hi_c;
      prod4  <= prod_c;
      res5   <= res_c;
    end
  end

  assign mult5_int_write_data_o   = res5;
  assign mult5_write_addr_o       = addr[4];
  assign mult5_int_write_enable_o = vld[4];
  assign mult5_instruction_o      = instr[4];
  assign mult5_pc_o               = pc[4];
  assign mult_pend_valid_o        = vld;
  assign mult_pend_addr_o         = {addr[4], addr[3], addr[2], addr[1], addr[0]};

endmodule

// File: tb/tb_mult_pipeline.sv
// Randomized bench for mult_pipeline with a cycle-indexed scoreboard of accepted multiplies.
module tb_mult_pipeline;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        kill_i;
  logic        mult_valid_i;
  logic [31:0] mult_rs1_data_i, mult_rs2_data_i;
  logic [4:0]  mult_write_addr_i;
  logic [31:0] mult_instruction_i, mult_pc_i;
  logic [31:0] mult5_int_write_data_o;
  logic [4:0]  mult5_write_addr_o;
  logic        mult5_int_write_enable_o;
  logic [31:0] mult5_instruction_o, mult5_pc_o;
  logic [4:0]  mult_pend_valid_o;
  logic [24:0] mult_pend_addr_o;

  mult_pipeline dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .kill_i(kill_i), .mult_valid_i(mult_valid_i),
    .mult_rs1_data_i(mult_rs1_data_i), .mult_rs2_data_i(mult_rs2_data_i),
    .mult_write_addr_i(mult_write_addr_i), .mult_instruction_i(mult_instruction_i),
    .mult_pc_i(mult_pc_i), .mult5_int_write_data_o(mult5_int_write_data_o),
    .mult5_write_addr_o(mult5_write_addr_o), .mult5_int_write_enable_o(mult5_int_write_enable_o),
    .mult5_instruction_o(mult5_instruction_o), .mult5_pc_o(mult5_pc_o),
    .mult_pend_valid_o(mult_pend_valid_o), .mult_pend_addr_o(mult_pend_addr_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] OPC = 7'b0110011;

  int n_chk = 0;
  int n_pass = 0;
  int e = 0;

  // Scoreboard slot (edge % 16): what was accepted at that edge.
  logic        sv   [16];
  logic [4:0]  sa   [16];
  logic [31:0] sins [16];
  logic [31:0] spc  [16];
  logic [31:0] sdat [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] f);
    logic signed [65:0] ea, eb, p;
    ea = (f == 2'b11) ? {34'b0, a} : {{34{a[31]}}, a};
    eb = f[1] ? {34'b0, b} : {{34{b[31]}}, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, OPC};
  endfunction

  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] pc,
                     input logic k);
    mult_valid_i = v; mult_instruction_i = ins; mult_rs1_data_i = a;
    mult_rs2_data_i = b; mult_write_addr_i = rd; mult_pc_i = pc; kill_i = k;
  endtask

  task automatic clr_slot(input int s);
    sv[s] = 0; sa[s] = 0; sins[s] = 0; spc[s] = 0; sdat[s] = 0;
  endtask

  task automatic check_outputs();
    int j;
    logic [4:0]  pv;
    logic [24:0] pa;
    j = (e - 4) & 15;
    chk("en",    mult5_int_write_enable_o, sv[j]);
    chk("data",  mult5_int_write_data_o,   sdat[j]);
    chk("addr",  mult5_write_addr_o,       sa[j]);
    chk("instr", mult5_instruction_o,      sins[j]);
    chk("pc",    mult5_pc_o,               spc[j]);
    for (int k = 0; k < 5; k++) begin
      pv[k] = sv[(e - k) & 15];
      pa[5*k +: 5] = sa[(e - k) & 15];
    end
    chk("pend_valid", mult_pend_valid_o, pv);
    chk("pend_addr",  mult_pend_addr_o,  pa);
  endtask

  task automatic tick();
    logic acc;
    int s;
    @(posedge clk_i);
    e++;
    s = e & 15;
    if (!rsn_i) begin
      for (int i = 0; i < 16; i++) clr_slot(i);
    end else if (kill_i) begin
      for (int k = 0; k < 5; k++) clr_slot((e - k) & 15);
    end else begin
      acc = mult_valid_i && mult_instruction_i[6:0] == OPC &&
            mult_instruction_i[31:25] == 7'b0000001 && !mult_instruction_i[14];
      clr_slot(s);
      if (acc) begin
        sv[s] = 1; sa[s] = mult_write_addr_i; sins[s] = mult_instruction_i;
        spc[s] = mult_pc_i;
        sdat[s] = ref_mul(mult_rs1_data_i, mult_rs2_data_i, mult_instruction_i[13:12]);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    put(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  logic [31:0] dir_a   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_b   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [1:0]  dir_f   [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [31:0] dir_exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

  initial begin
    for (int i = 0; i < 16; i++) clr_slot(i);
    rsn_i = 0;
    put(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_en",   mult5_int_write_enable_o, 0);
    chk("rst_pend", mult_pend_valid_o, 0);
    chk("rst_data", mult5_int_write_data_o, 0);
    @(posedge clk_i);
    #2 rsn_i = 1;

    // Directed ops
    for (int i = 0; i < 4; i++) begin
      put(1, mk(7'd1, {1'b0, dir_f[i]}, 5'(i + 10)), dir_a[i], dir_b[i], 5'(i + 10),
          32'h1000 + 32'(4 * i), 0);
      tick();
      idle(4);
      chk("dir_data", mult5_int_write_data_o, dir_exp[i]);
      chk("dir_en", mult5_int_write_enable_o, 1);
      chk("dir_addr", mult5_write_addr_o, 5'(i + 10));
      chk("dir_pc", mult5_pc_o, 32'h1000 + 32'(4 * i));
    end
    idle(2);

    // Back-to-back ramp
    for (int i = 1; i <= 6; i++) begin
      put(1, mk(7'd1, 3'b000, 5'(i)), $urandom, $urandom, 5'(i), 32'h2000 + 32'(i), 0);
      tick();
      chk("ramp_pend", mult_pend_valid_o, (i <= 5) ? 5'((1 << i) - 1) : 5'h1F);
    end
    idle(6);
    chk("drain_pend", mult_pend_valid_o, 0);

    // Filtering
    put(1, mk(7'd1, 3'b100, 5'd3), 32'd9, 32'd3, 5'd3, 32'h3000, 0); tick();
    chk("flt_div", mult_pend_valid_o, 0);
    put(1, mk(7'd0, 3'b000, 5'd4), 32'd9, 32'd3, 5'd4, 32'h3004, 0); tick();
    chk("flt_add", mult_pend_valid_o, 0);
    put(0, mk(7'd1, 3'b000, 5'd5), 32'd9, 32'd3, 5'd5, 32'h3008, 0); tick();
    chk("flt_nv", mult_pend_valid_o, 0);
    idle(5);

    // Kill
    for (int i = 0; i < 3; i++) begin
      put(1, mk(7'd1, 3'b001, 5'(i + 20)), $urandom, $urandom, 5'(i + 20), 32'h4000, 0);
      tick();
    end
    put(1, mk(7'd1, 3'b000, 5'd23), 32'd5, 32'd6, 5'd23, 32'h4010, 1);
    tick();
    chk("kill_pend", mult_pend_valid_o, 0);
    put(1, mk(7'd1, 3'b000, 5'd24), 32'd5, 32'd6, 5'd24, 32'h4014, 0);
    tick();
    idle(4);
    chk("kill_next_en", mult5_int_write_enable_o, 1);
    chk("kill_next_data", mult5_int_write_data_o, 32'd30);
    idle(2);

    // Async reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      put(1, mk(7'd1, 3'b011, 5'(i + 1)), $urandom, $urandom, 5'(i + 1), 32'h5000, 0);
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0);
    #2 rsn_i = 0;
    #1;
    chk("arst_pend", mult_pend_valid_o, 0);
    chk("arst_paddr", mult_pend_addr_o, 0);
    chk("arst_en", mult5_int_write_enable_o, 0);
    chk("arst_data", mult5_int_write_data_o, 0);
    chk("arst_pc", mult5_pc_o, 0);
    tick();
    rsn_i = 1;
    put(1, mk(7'd1, 3'b000, 5'd9), 32'd11, 32'd3, 5'd9, 32'h6000, 0);
    tick();
    idle(4);
    chk("arst_next_en", mult5_int_write_enable_o, 1);
    chk("arst_next_data", mult5_int_write_data_o, 32'd33);
    idle(2);

    // Random regression
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] ins;
      int r;
      logic [4:0] rd;
      rd = 5'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       ins = mk(7'd1, {1'b0, 2'($urandom)}, rd);
      else if (r == 7) ins = mk(7'd1, {1'b1, 2'($urandom)}, rd);
      else             ins = $urandom;
      put($urandom_range(0, 9) != 0, ins, $urandom, $urandom, rd, $urandom,
          $urandom_range(0, 29) == 0);
      tick();
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_pipeline.md
# mult_pipeline

Five-stage pipelined integer multiplier implementing the RV32M MUL, MULH, MULHSU and MULHU instructions.
- Sits beside the ALU in the execute stage and is fed by the decode/execute latch.
- Its stage-5 outputs drive the mult5_* inputs of the execute/write-back latch, which gives them top priority.
- The pipeline never stalls. One multiply may enter per cycle.
- It exports its in-flight destination registers so decode can detect hazards.

## Interface
- No parameters. Latency is fixed at 5 stages.
- clk_i  in  1  clock; all registers update on the rising edge.
- rsn_i  in  1  asynchronous, active-low reset.
- kill_i  in  1  synchronous flush of every stage.
- mult_valid_i  in  1  a candidate multiply is presented this cycle.
- mult_rs1_data_i  in  32  operand A.
- mult_rs2_data_i  in  32  operand B.
- mult_write_addr_i  in  5  destination register.
- mult_instruction_i  in  32  instruction word.
- mult_pc_i  in  32  instruction PC.
- mult5_int_write_data_o  out  32  result.
- mult5_write_addr_o  out  5  destination register.
- mult5_int_write_enable_o  out  1  stage 5 holds a valid result.
- mult5_instruction_o  out  32  instruction word.
- mult5_pc_o  out  32  instruction PC.
- mult_pend_valid_o  out  5  bit i-1 set means stage Mi is valid.
- mult_pend_addr_o  out  25  bits [5i-1:5i-5] hold the Mi destination register.

## Operation
- **Acceptance.** An input is accepted only when all of these hold:
  - mult_valid_i=1
  - instruction[6:0]=0110011
  - instruction[31:25]=0000001
  - instruction[14]=0
- Anything else, including DIV/REM encodings, inserts a bubble into M1.
- **Operation select** uses instruction[13:12]. Operands are extended to 33 bits and their signed 66-bit product is formed.

| funct3[1:0] | Op | A extension | B extension | Result |
|---|---|---|---|---|
| 00 | MUL | sign | sign | product[31:0] |
| 01 | MULH | sign | sign | product[63:32] |
| 10 | MULHSU | sign | zero | product[63:32] |
| 11 | MULHU | zero | zero | product[63:32] |

- **Partitioning.** How the partial products are split across M1..M5 is an implementation choice. The final result must be registered in M5.
- **Sideband.** Each stage Mi carries valid, address, instruction, PC and its partial data. Every valid stage advances one stage per cycle, unconditionally.
- **Bubbles.** When a stage is invalid, its address, instruction, PC and data registers are cleared to 0. Consequently every mult5_* output reads 0 whenever mult5_int_write_enable_o=0.
- **Destination x0.** A multiply with rd=x0 still propagates with enable=1. Downstream is responsible for ignoring x0.
- **Kill.** kill_i=1 at an edge clears valid and all fields in M1..M5. An input presented in the same cycle is dropped; kill wins.
- **Reset.** rsn_i=0 asynchronously clears all stage registers, including mid-operation. All outputs read 0 while reset is held and after it releases.

## Timing
- **Latency.** An input accepted at edge k enters M1 at edge k and appears on the mult5_* outputs after edge k+4. The outputs are therefore valid in the cycle following edge k+4, i.e. 5 cycles after presentation.
- **Throughput.** One multiply per cycle. Back-to-back inputs emerge back-to-back in order, with no gaps.
- **Pending outputs.** mult_pend_valid_o and mult_pend_addr_o are direct register outputs.
  - mult_pend_valid_o[0] reflects M1.
  - mult_pend_valid_o[4] equals mult5_int_write_enable_o.
- **No combinational paths.** No output depends combinationally on any input.
- **Clearing.** Kill clears all stages at the edge where it is sampled. Reset clears them immediately on assertion.

## Test plan
- **Directed ops, 4 cycles apart:**
  - MUL 7×0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - For each: enable, addr, instruction and PC appear exactly 5 cycles after presentation, and enable is high for 1 cycle only.
- **Back-to-back:** 6 consecutive MULs with rd=1..6 → 6 consecutive enable-high cycles in order with correct results. mult_pend_valid_o ramps 00001→11111, then drains back to 0.
- **Filtering:** a DIV (funct3=100), an ADD (funct7=0) and mult_valid_i=0 with a MUL encoding → no enable at stage 5 and mult_pend_valid_o stays 0.
- **Kill:** 3 MULs in flight, then kill_i asserted together with a new MUL → all pending bits 0 on the next cycle and no stage-5 enable for any of the 4 multiplies. A MUL issued the cycle after kill completes normally.
- **Async reset:** assert rsn_i=0 mid-cycle with 4 MULs in flight → all outputs 0 immediately, before the next clock edge. After release, a new MUL completes with 5-cycle latency.
- **Random regression:** 10k random operands and ops against a 64-bit reference model, with random kill_i → results, ordering and flush behaviour must match.
